// File: rtl/morse_decoder_if.sv
// Symbol-event and character-output bundle between the Morse timing stage,
// the decoder and the downstream text buffer.
interface morse_decoder_if;
  logic       dot;
  logic       dash;
  logic       interchar;
  logic       interword;
  logic [7:0] char_code;
  logic       char_valid;
  logic       error;

  modport master (
    output dot, dash, interchar, interword,
    input  char_code, char_valid, error
  );

  modport slave (
    input  dot, dash, interchar, interword,
    output char_code, char_valid, error
  );
endinterface

// File: rtl/morse_decoder.sv
// Accumulates dot/dash events into a (len, pat) key and emits the decoded
// ASCII character, plus a single space on word gaps, as one-cycle pulses.
module morse_decoder #(
  parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
  input logic             clk,
  input logic             reset,
  morse_decoder_if.slave  bus
);

  // state       | meaning
  // S_IDLE      | collecting symbols, waiting for a gap
  // S_EMIT_CHAR | registering the looked-up character
  // S_EMIT_SPACE| registering an ASCII space
  typedef enum logic [1:0] {S_IDLE, S_EMIT_CHAR, S_EMIT_SPACE} state_t;

  state_t     state_q, state_d;
  logic [4:0] pat_q, key_pat_q;
  logic [2:0] len_q, key_len_q;
  logic       ovf_q, key_ovf_q;
  logic       space_pend_q, last_space_q;
  logic       pend_char_q, pend_word_q;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d, err_q, err_d;

  logic       word_evt, char_evt, gap_now, sym_valid, sym, take_key;
  logic [7:0] lk_code;
  logic       lk_err;

  always_comb begin
    word_evt  = 1'b0;
    char_evt  = 1'b0;
    if (state_q == S_IDLE) begin
      word_evt = bus.interword | pend_word_q;
      char_evt = ~word_evt & (bus.interchar | pend_char_q);
    end
    gap_now   = bus.interword | bus.interchar | word_evt | char_evt;
    sym_valid = (bus.dot | bus.dash) & ~gap_now;
    sym       = ~bus.dot;
    take_key  = (word_evt | char_evt) && (len_q != 3'd0);
  end

  // Key is {len, pat} with the first symbol in the MSB of the used bits.
  always_comb begin
    lk_code = UNKNOWN_CHAR;
    lk_err  = 1'b0;
    case ({key_len_q, key_pat_q})
      {3'd1, 5'b00000}: lk_code = "E";
      {3'd1, 5'b00001}: lk_code = "T";
      {3'd2, 5'b00000}: lk_code = "I";
      {3'd2, 5'b00001}: lk_code = "A";
      {3'd2, 5'b00010}: lk_code = "N";
      {3'd2, 5'b00011}: lk_code = "M";
      {3'd3, 5'b00000}: lk_code = "S";
      {3'd3, 5'b00001}: lk_code = "U";
      {3'd3, 5'b00010}: lk_code = "R";
      {3'd3, 5'b00011}: lk_code = "W";
      {3'd3, 5'b00100}: lk_code = "D";
      {3'd3, 5'b00101}: lk_code = "K";
      {3'd3, 5'b00110}: lk_code = "G";
      {3'd3, 5'b00111}: lk_code = "O";
      {3'd4, 5'b00000}: lk_code = "H";
      {3'd4, 5'b00001}: lk_code = "V";
      {3'd4, 5'b00010}: lk_code = "F";
      {3'd4, 5'b00100}: lk_code = "L";
      {3'd4, 5'b00110}: lk_code = "P";
      {3'd4, 5'b00111}: lk_code = "J";
      {3'd4, 5'b01000}: lk_code = "B";
      {3'd4, 5'b01001}: lk_code = "X";
      {3'd4, 5'b01010}: lk_code = "C";
      {3'd4, 5'b01011}: lk_code = "Y";
      {3'd4, 5'b01100}: lk_code = "Z";
      {3'd4, 5'b01101}: lk_code = "Q";
      {3'd5, 5'b11111}: lk_code = "0";
      {3'd5, 5'b01111}: lk_code = "1";
      {3'd5, 5'b00111}: lk_code = "2";
      {3'd5, 5'b00011}: lk_code = "3";
      {3'd5, 5'b00001}: lk_code = "4";
      {3'd5, 5'b00000}: lk_code = "5";
      {3'd5, 5'b10000}: lk_code = "6";
      {3'd5, 5'b11000}: lk_code = "7";
      {3'd5, 5'b11100}: lk_code = "8";
      {3'd5, 5'b11110}: lk_code = "9";
      default: begin
        lk_code = UNKNOWN_CHAR;
        lk_err  = 1'b1;
      end
    endcase
    if (key_ovf_q) begin
      lk_code = UNKNOWN_CHAR;
      lk_err  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take_key)
          state_d = S_EMIT_CHAR;
        else if (word_evt && !last_space_q)
          state_d = S_EMIT_SPACE;
      end
      S_EMIT_CHAR: begin
        valid_d = 1'b1;
        code_d  = lk_code;
        err_d   = lk_err;
        state_d = space_pend_q ? S_EMIT_SPACE : S_IDLE;
      end
      S_EMIT_SPACE: begin
        valid_d = 1'b1;
        code_d  = 8'h20;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pat_q        <= 5'd0;
      len_q        <= 3'd0;
      ovf_q        <= 1'b0;
      key_pat_q    <= 5'd0;
      key_len_q    <= 3'd0;
      key_ovf_q    <= 1'b0;
      space_pend_q <= 1'b0;
      last_space_q <= 1'b1;
      pend_char_q  <= 1'b0;
      pend_word_q  <= 1'b0;
      code_q       <= 8'h00;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;

      if (take_key) begin
        key_len_q <= len_q;
        key_pat_q <= pat_q;
        key_ovf_q <= ovf_q;
        len_q     <= 3'd0;
        pat_q     <= 5'd0;
        ovf_q     <= 1'b0;
      end else if (sym_valid) begin
        len_q <= (len_q == 3'd6) ? 3'd6 : len_q + 3'd1;
        if (len_q >= 3'd5)
          ovf_q <= 1'b1;
        else
          pat_q <= {pat_q[3:0], sym};
      end

      case (state_q)
        S_IDLE: begin
          pend_char_q <= 1'b0;
          pend_word_q <= 1'b0;
          if (take_key && word_evt)
            space_pend_q <= 1'b1;
        end
        S_EMIT_CHAR:  last_space_q <= 1'b0;
        S_EMIT_SPACE: begin
          last_space_q <= 1'b1;
          space_pend_q <= 1'b0;
        end
        default: ;
      endcase

      // Gaps seen mid-emission are held until IDLE; a word gap outranks a char gap.
      if (state_q != S_IDLE && len_q != 3'd0) begin
        if (bus.interword) begin
          pend_word_q <= 1'b1;
          pend_char_q <= 1'b0;
        end else if (bus.interchar && !pend_word_q) begin
          pend_char_q <= 1'b1;
        end
      end
    end
  end

  assign bus.char_code  = code_q;
  assign bus.char_valid = valid_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench: directed scenarios plus randomized words checked
// against a string-based Morse reference model.
module tb_morse_decoder;
  localparam logic [3:0] DOT = 4'b0001, DASH = 4'b0010, IC = 4'b0100, IW = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  morse_decoder_if bus();

  morse_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic [8:0] exp_q[$];

  string morse_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                           "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                           "--...", "---..", "----."};
  string char_str = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  always @(negedge clk) begin
    cyc++;
    if (bus.char_valid) begin
      got_q.push_back({bus.error, bus.char_code});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    bus.dot = 0; bus.dash = 0; bus.interchar = 0; bus.interword = 0;
  end

  // Called at posedge+1; leaves v asserted for exactly one sampling edge.
  task automatic step(input logic [3:0] v);
    {bus.interword, bus.interchar, bus.dash, bus.dot} = v;
    @(posedge clk); #1;
    {bus.interword, bus.interchar, bus.dash, bus.dot} = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000);
  endtask

  task automatic send_sym(input string s);
    for (int i = 0; i < s.len(); i++) begin
      step(s[i] == "." ? DOT : DASH);
      step(4'b0000);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    got_cyc.delete();
  endtask

  function automatic logic [8:0] ref_lookup(input string s);
    for (int i = 0; i < 36; i++)
      if (s == morse_tab[i]) return {1'b0, char_str[i]};
    return {1'b1, 8'h3F};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++; if (bus.char_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.char_valid); end
    tests++; if (bus.error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", bus.error); end
    tests++; if (bus.char_code !== 8'h00) begin fails++; $display("FAIL reset_code: got %h expected 00", bus.char_code); end
    got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_latency_a();
    send_sym(".-");
    {bus.interword, bus.interchar, bus.dash, bus.dot} = IC;
    @(posedge clk); #1;
    bus.interchar = 1'b0;
    tests++; if (bus.char_valid !== 1'b0) begin fails++; $display("FAIL a_early: got valid %b expected 0 at T", bus.char_valid); end
    @(posedge clk); #1;
    tests++; if (bus.char_valid !== 1'b1) begin fails++; $display("FAIL a_valid: got %b expected 1 at T+1", bus.char_valid); end
    tests++; if ({bus.error, bus.char_code} !== {1'b0, 8'h41}) begin fails++; $display("FAIL a_code: got %b/%h expected 0/41", bus.error, bus.char_code); end
    @(posedge clk); #1;
    tests++; if (bus.char_valid !== 1'b0 || bus.char_code !== 8'h41) begin fails++; $display("FAIL a_hold: got %b/%h expected 0/41", bus.char_valid, bus.char_code); end
    idle(2);
  endtask

  task automatic test_sos();
    logic [8:0] e[4] = '{9'h053, 9'h04F, 9'h053, 9'h020};
    got_q.delete(); got_cyc.delete();
    send_sym("..."); step(IC); idle(2);
    send_sym("---"); step(IC); idle(2);
    send_sym("..."); step(IW); idle(4);
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL sos_count: got %0d expected 4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (got_q[i] !== e[i]) begin fails++; $display("FAIL sos[%0d]: got %h expected %h", i, got_q[i], e[i]); end
      end
      tests++; if (got_cyc[3] != got_cyc[2] + 1) begin fails++; $display("FAIL sos_space_gap: got %0d cycles expected 1", got_cyc[3] - got_cyc[2]); end
    end
  endtask

  task automatic test_digits_overflow();
    logic [8:0] e[4] = '{9'h035, 9'h030, 9'h13F, 9'h045};
    got_q.delete();
    send_sym("....."); step(IC); idle(2);
    send_sym("-----"); step(IC); idle(2);
    send_sym("......"); step(IC); idle(2);
    send_sym("."); step(IC); idle(3);
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL dig_count: got %0d expected 4", got_q.size()); end
    else
      for (int i = 0; i < 4; i++) begin
        tests++; if (got_q[i] !== e[i]) begin fails++; $display("FAIL dig_ovf[%0d]: got %h expected %h", i, got_q[i], e[i]); end
      end
  endtask

  task automatic test_space_suppress();
    do_reset();
    step(IW); idle(3);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL lead_space: got %0d outputs expected 0", got_q.size()); end
    send_sym("."); step(IC); idle(2);
    step(IW); idle(2); step(IW); idle(3);
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL dup_space_count: got %0d expected 2", got_q.size()); end
    else begin
      tests++; if (got_q[1] !== 9'h020) begin fails++; $display("FAIL dup_space: got %h expected 020", got_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_sym(".-");
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    step(IC); idle(3);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_mid_char: got %0d outputs expected 0", got_q.size()); end
    send_sym("-"); step(IC); idle(3);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 9'h054) begin fails++; $display("FAIL rst_then_t: got %0d outputs first %h expected 1 of 054", got_q.size(), got_q.size() ? got_q[0] : 9'h0); end
    got_q.delete();
    step(DOT); step(IW);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    idle(4);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_mid_emit: got %0d outputs expected 0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e[3] = '{9'h045, 9'h020, 9'h054};
    do_reset();
    step(DOT); step(IW); step(DASH); step(IC); idle(5);
    tests++;
    if (got_q.size() != 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
    else
      for (int i = 0; i < 3; i++) begin
        tests++; if (got_q[i] !== e[i]) begin fails++; $display("FAIL b2b[%0d]: got %h expected %h", i, got_q[i], e[i]); end
      end
  endtask

  task automatic test_random();
    string cur;
    bit    last_space;
    int    n;
    do_reset();
    exp_q.delete();
    last_space = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 3) != 0) cur = morse_tab[$urandom_range(0, 35)];
        else begin
          cur = "";
          n = $urandom_range(1, 7);
          for (int j = 0; j < n; j++) cur = {cur, ($urandom_range(0, 1) != 0) ? "-" : "."};
        end
        for (int j = 0; j < cur.len(); j++) begin
          step(cur[j] == "." ? DOT : DASH);
          idle($urandom_range(1, 2));
        end
      end else cur = "";
      if ($urandom_range(0, 2) == 0) begin
        step(IW);
        if (cur.len() > 0) begin exp_q.push_back(ref_lookup(cur)); exp_q.push_back(9'h020); last_space = 1'b1; end
        else if (!last_space) begin exp_q.push_back(9'h020); last_space = 1'b1; end
      end else begin
        step(IC);
        if (cur.len() > 0) begin exp_q.push_back(ref_lookup(cur)); last_space = 1'b0; end
      end
      idle(3);
    end
    idle(3);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency_a();
    test_sos();
    test_digits_overflow();
    test_space_suppress();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Converts the symbol event stream produced by the Morse timing stage (one-cycle `dot`, `dash`, `interchar` and `interword` pulses) into ASCII characters. Each character is delivered as a one-cycle valid pulse to the display/text-buffer stage downstream. Symbols are accumulated into a pattern register, and the pattern is looked up when a character or word gap arrives. Word gaps also emit an ASCII space.

## Interface

Parameters:
- `UNKNOWN_CHAR`, default 8'h3F (`?`): code emitted for an unrecognised or overflowed pattern.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `dot`  in  1  one-cycle pulse: a short symbol was completed.
- `dash`  in  1  one-cycle pulse: a long symbol was completed.
- `interchar`  in  1  one-cycle pulse: character gap detected.
- `interword`  in  1  one-cycle pulse: word gap detected.
- `char_code`  out  8  ASCII code; meaningful only while `char_valid`=1.
- `char_valid`  out  1  one-cycle pulse: `char_code` holds a new character.
- `error`  out  1  one-cycle pulse, coincident with `char_valid`, when `UNKNOWN_CHAR` is emitted.

## Operation

Accumulator:
- The accumulator consists of `pat[4:0]` and `len[2:0]`.
- Symbol encoding: dot=0, dash=1.
- Each accepted symbol updates `pat <= {pat[3:0], sym}` and `len <= len+1`.
- `len` saturates at 6. A symbol arriving at len≥5 sets the internal sticky `ovf` flag; `pat` is no longer updated.

Input priority within one cycle: `interword` > `interchar` > `dot` > `dash`.
- If `dot` and `dash` are both high, only `dot` is taken.
- A gap pulse in the same cycle as a symbol: the symbol is dropped.

Lookup key is (`len`, `pat`):
- Letters A–Z use len 1–4.
- Digits 0–9 use len 5.
- Standard international Morse is used. Examples: A=(2,01); E=(1,0); T=(1,1); S=(3,000); O=(3,111); 5=(5,00000); 0=(5,11111).
- Any other key, or `ovf`=1, yields `UNKNOWN_CHAR` with `error`=1.

Gap events:
- On a gap event, the key is captured into a lookup register and the accumulator clears (len=0, pat=0, ovf=0) in the same cycle. Symbols arriving on the next cycle therefore start a new character.

State machine:
- IDLE:
  - `interchar` with len>0 → EMIT_CHAR.
  - `interword` with len>0 → EMIT_CHAR, with `space_pend` set.
  - `interword` with len=0 and `last_space`=0 → EMIT_SPACE.
  - `interchar` with len=0 → ignored; stay in IDLE.
  - `interword` with len=0 and `last_space`=1 → ignored; stay in IDLE.
- EMIT_CHAR (1 cycle):
  - Drives `char_valid`=1 with the looked-up code and clears `last_space`.
  - Next state is EMIT_SPACE if `space_pend`, else IDLE.
- EMIT_SPACE (1 cycle):
  - Drives `char_valid`=1 with `char_code`=8'h20, sets `last_space`, clears `space_pend`, then → IDLE.
- Symbols are accepted into the accumulator in every state.
- Gap pulses arriving in EMIT_CHAR or EMIT_SPACE see len=0 unless a symbol was accepted there. If len>0, they are latched as one pending gap and serviced on return to IDLE. A second gap overwrites the pending one, with interword winning.

## Timing

- Reset values:
  - Outputs: `char_valid`=0, `error`=0, `char_code`=8'h00.
  - Internal: state=IDLE, len=0, pat=0, ovf=0, `space_pend`=0, `last_space`=1. The initial `last_space`=1 suppresses a leading space.
- Latency, with a gap pulse sampled at edge T:
  - Character emitted at T+1.
  - Space (if any) emitted at T+2.
- `char_code` holds its last value when `char_valid`=0.
- Reset mid-character or mid-emission: the accumulator and any pending emission are discarded. No `char_valid` follows.
- Upstream events are at least one cycle apart, so no back-pressure is needed. Throughput is at most 2 cycles per gap.

## Test plan

- dot, dash, interchar → `char_valid` at T+1, `char_code`=8'h41 (`A`), `error`=0.
- S/O/S: 3×dot, interchar, 3×dash, interchar, 3×dot, interword → output sequence 8'h53, 8'h4F, 8'h53, 8'h20. The final space arrives one cycle after the last S.
- 5×dot, interchar → 8'h35. Then 5×dash, interchar → 8'h30.
- 6×dot, interchar → 8'h3F with `error`=1. A following dot, interchar → 8'h45 (`E`); overflow was cleared.
- Reset then interword, or interword twice after `E` → exactly one space total. The leading space after reset is suppressed, and a duplicate space is never emitted.
- dot, dash, reset pulse, interchar → no `char_valid`. The next dash, interchar → 8'h54 (`T`).
